// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator.
// Takes one command from a valid/ready port and runs one cyc/stb cycle on the
// peripheral bus. It returns the read data, or a timeout error when no slave
// acknowledges within TIMEOUT_CYCLES.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready_o high
// BUS   | cyc/stb driven, waiting for ack or for the timeout terminal count
// RESP  | response held on rsp_*, waiting for rsp_ready_i
module wb_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter starts at 0 on the first BUS cycle. Reaching this value
  // without an ack means cyc/stb have been high for TIMEOUT_CYCLES cycles.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic [3:0]           sel_q, sel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;

  // State and all registered outputs. The asynchronous reset drops cyc/stb at
  // once, so an abandoned transfer never leaks onto the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and next-output decode. Every register holds by default, which
  // keeps the bus fields stable after a transfer and the response stable in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end

      BUS: begin
        // When ack and the terminal count coincide, the ack wins.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // Only IDLE accepts commands. Because this output is decoded from state, a
  // command cannot be accepted on the same edge that retires a response.
  assign cmd_ready_o = (state_q == IDLE);

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Self-checking bench for wb_host_master. It uses a vector table for single
// transfers, a response scoreboard, and hand sequences for backpressure, a
// held ack and reset during a transfer.
module tb_wb_host_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;

  wb_host_master #(.TIMEOUT_CYCLES(16), .CNT_WIDTH(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  // 100 MHz clock
  always #5 clk_i = ~clk_i;

  // ack_cyc: BUS cycle (1-based) on which the slave acks; 0 means never
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_cyc;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: response with empty scoreboard, got dat %h err %b", name, rsp_dat_o, rsp_err_o);
    end else begin
      e = sb.pop_front();
      check({name, "_dat"}, rsp_dat_o, e.dat);
      check({name, "_err"}, 32'(rsp_err_o), 32'(e.err));
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cnt;
    string tag;
    tag = $sformatf("v%0d", idx);
    wbm_ack_i   = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    cmd_sel_i   = v.sel;
    @(posedge clk_i);
    #1;
    check({tag, "_accept_cyc"}, 32'(wbm_cyc_o), 32'd1);
    sb.push_back('{dat: v.exp_dat, err: v.exp_err});
    // Garbage on the command port while busy must be ignored.
    cmd_valid_i = 1'b0;
    cmd_adr_i   = 32'hFFFF_FFFF;
    cmd_dat_i   = ~v.dat;
    cmd_sel_i   = ~v.sel;
    cmd_we_i    = ~v.we;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (!wbm_cyc_o) break;
      cnt++;
      check({tag, "_stb"}, 32'(wbm_stb_o), 32'd1);
      check({tag, "_adr"}, wbm_adr_o, v.adr);
      check({tag, "_wdat"}, wbm_dat_o, v.dat);
      check({tag, "_sel"}, 32'(wbm_sel_o), 32'(v.sel));
      check({tag, "_we"}, 32'(wbm_we_o), 32'(v.we));
      wbm_ack_i = (cnt == v.ack_cyc);
      wbm_dat_i = (cnt == v.ack_cyc) ? v.rdata : $urandom;
    end
    wbm_ack_i = 1'b0;
    check({tag, "_cyc_len"}, 32'(cnt), 32'(v.exp_cyc));
    check({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    if (rsp_valid_o) check_rsp(tag);
    @(negedge clk_i);
    check({tag, "_rsp_clr"}, 32'(rsp_valid_o), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready_o), 32'd1);
    check({tag, "_adr_hold"}, wbm_adr_o, v.adr);
    check({tag, "_wdat_hold"}, wbm_dat_o, v.dat);
    check({tag, "_cyc_idle"}, 32'(wbm_cyc_o), 32'd0);
  endtask

  // Watchdog so the run always ends even if the DUT wedges a wait.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main test sequence.
  initial begin
    vecs[0] = '{we:1'b1, adr:32'h3001_0000, dat:32'h00A5_5A5A, sel:4'hF, ack_cyc:2,
                rdata:32'hDEAD_BEEF, exp_dat:32'h0, exp_err:1'b0, exp_cyc:2};
    vecs[1] = '{we:1'b0, adr:32'h3001_0004, dat:32'h0, sel:4'hF, ack_cyc:3,
                rdata:32'h0012_3456, exp_dat:32'h0012_3456, exp_err:1'b0, exp_cyc:3};
    vecs[2] = '{we:1'b0, adr:32'h3001_0008, dat:32'h0, sel:4'hF, ack_cyc:0,
                rdata:32'hCAFE_F00D, exp_dat:32'h0, exp_err:1'b1, exp_cyc:16};
    vecs[3] = '{we:1'b0, adr:32'h3001_000C, dat:32'h0, sel:4'hF, ack_cyc:16,
                rdata:32'h89AB_CDEF, exp_dat:32'h89AB_CDEF, exp_err:1'b0, exp_cyc:16};
    vecs[4] = '{we:1'b1, adr:32'h3001_0010, dat:32'h1122_3344, sel:4'h3, ack_cyc:1,
                rdata:32'h7777_7777, exp_dat:32'h0, exp_err:1'b0, exp_cyc:1};
    vecs[5] = '{we:1'b0, adr:32'h3001_0014, dat:32'h0, sel:4'hC, ack_cyc:15,
                rdata:32'h5555_AAAA, exp_dat:32'h5555_AAAA, exp_err:1'b0, exp_cyc:15};
    vecs[6] = '{we:1'b1, adr:32'h3001_0018, dat:32'hA1B2_C3D4, sel:4'hF, ack_cyc:17,
                rdata:32'h1234_5678, exp_dat:32'h0, exp_err:1'b1, exp_cyc:16};

    // Reset state
    #1;
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check("rst_stb", 32'(wbm_stb_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    check("rst_rsp_dat", rsp_dat_o, 32'h0);
    check("rst_adr", wbm_adr_o, 32'h0);
    check("rst_wdat", wbm_dat_o, 32'h0);
    check("rst_we", 32'(wbm_we_o), 32'd0);
    check("rst_sel", 32'(wbm_sel_o), 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Backpressure with an ack held high: one transfer per command only, and
    // the queued command waits one cycle past the response handshake.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b1;
    wbm_dat_i   = 32'h0BAD_F00D;
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h3001_0020;
    cmd_sel_i   = 4'hF;
    @(posedge clk_i);
    #1;
    check("bp_accept_cyc", 32'(wbm_cyc_o), 32'd1);
    sb.push_back('{dat: 32'h0BAD_F00D, err: 1'b0});
    cmd_adr_i = 32'h3001_0024;
    @(posedge clk_i);
    #1;
    check("bp_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
    if (rsp_valid_o) check_rsp("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
      check("bp_hold_dat", rsp_dat_o, 32'h0BAD_F00D);
      check("bp_hold_err", 32'(rsp_err_o), 32'd0);
      check("bp_hold_ready", 32'(cmd_ready_o), 32'd0);
      check("bp_hold_cyc", 32'(wbm_cyc_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("bp_hs_valid", 32'(rsp_valid_o), 32'd0);
    check("bp_hs_ready", 32'(cmd_ready_o), 32'd1);
    check("bp_hs_no_accept", 32'(wbm_cyc_o), 32'd0);
    wbm_dat_i = 32'h600D_CAFE;
    @(posedge clk_i);
    #1;
    check("bp2_accept_cyc", 32'(wbm_cyc_o), 32'd1);
    check("bp2_adr", wbm_adr_o, 32'h3001_0024);
    sb.push_back('{dat: 32'h600D_CAFE, err: 1'b0});
    cmd_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    wbm_ack_i = 1'b0;
    check("bp2_cyc_drop", 32'(wbm_cyc_o), 32'd0);
    check("bp2_rsp_valid", 32'(rsp_valid_o), 32'd1);
    if (rsp_valid_o) check_rsp("bp2");
    @(posedge clk_i);
    #1;
    check("bp2_rsp_clr", 32'(rsp_valid_o), 32'd0);

    // Reset in the middle of BUS, then a late ack.
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = 32'h3001_0030;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    check("rb_accept_cyc", 32'(wbm_cyc_o), 32'd1);
    repeat (3) @(posedge clk_i);
    #2;
    check("rb_cyc_before", 32'(wbm_cyc_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rb_cyc_async", 32'(wbm_cyc_o), 32'd0);
    check("rb_stb_async", 32'(wbm_stb_o), 32'd0);
    check("rb_ready_async", 32'(cmd_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni    = 1'b1;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hBADB_AD00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("rb_late_valid", 32'(rsp_valid_o), 32'd0);
      check("rb_late_cyc", 32'(wbm_cyc_o), 32'd0);
      check("rb_late_ready", 32'(cmd_ready_o), 32'd1);
    end
    wbm_ack_i = 1'b0;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
